// File: rtl/mdu_hilo_unit.sv
// Iterative multiply/divide unit with HI/LO registers for the EX stage.
// Optional MDU_FAST_MUL_EN: single-cycle combinational MULT/MULTU; DIV stays iterative.
module mdu_hilo_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             op_valid_e,
   input  logic [2:0]       op_e,
   input  logic [WIDTH-1:0] srca_e,
   input  logic [WIDTH-1:0] srcb_e,
   input  logic             flush_e,
   output logic             stall_req,
   output logic             busy,
   output logic [WIDTH-1:0] hilo_rdata,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_zero
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0]     ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2*WIDTH-1:0]   ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MFHI  = 3'd4;
   localparam logic [2:0] OP_MFLO  = 3'd5;
   localparam logic [2:0] OP_MTHI  = 3'd6;
   localparam logic [2:0] OP_MTLO  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } state_t;

   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
      return neg ? (~v + ONE_W) : v;
   endfunction

   state_t             state_q, state_d;
   logic               busy_q, busy_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0]   opb_q, opb_d;
   logic               neg_q, neg_d;
   logic               rneg_q, rneg_d;
   logic               div_q, div_d;
   logic               dz_q, dz_d;
   logic [WIDTH-1:0]   raw_q, raw_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               div_zero_q, div_zero_d;

   logic               accept_s;
   logic               sa_s;
   logic               sb_s;
   logic [WIDTH:0]     trial_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quo_s;
   logic [WIDTH-1:0]   rem_s;

   assign stall_req  = busy_q & op_valid_e;
   assign accept_s   = op_valid_e & ~flush_e & ~stall_req;
   assign sa_s       = ~op_e[0] & srca_e[WIDTH-1];
   assign sb_s       = ~op_e[0] & srcb_e[WIDTH-1];

   // Restoring divide: acc holds {remainder, dividend/quotient}; trial on shifted remainder.
   assign trial_s    = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opa_q[WIDTH-1:0]};

   assign prod_s     = neg_q  ? (~acc_q + ONE_2W) : acc_q;
   assign quo_s      = neg_q  ? (~acc_q[WIDTH-1:0] + ONE_W) : acc_q[WIDTH-1:0];
   assign rem_s      = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + ONE_W) : acc_q[2*WIDTH-1:WIDTH];

`ifdef MDU_FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_prod_s;
   // Low 2*WIDTH bits of the product of sign/zero-extended operands give both MULT and MULTU.
   assign fast_prod_s = {{WIDTH{sa_s}}, srca_e} * {{WIDTH{sb_s}}, srcb_e};
`endif

   assign hi         = hi_q;
   assign lo         = lo_q;
   assign busy       = busy_q;
   assign div_zero   = div_zero_q;
   assign hilo_rdata = (op_e == OP_MFHI) ? hi_q : lo_q;

   // Next-state logic for the iteration FSM and the architectural HI/LO registers.
   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      opa_d      = opa_q;
      opb_d      = opb_q;
      neg_d      = neg_q;
      rneg_d     = rneg_q;
      div_d      = div_q;
      dz_d       = dz_q;
      raw_d      = raw_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      div_zero_d = div_zero_q;

      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               case (op_e)
                  OP_MULT, OP_MULTU: begin
                     div_zero_d = 1'b0;
`ifdef MDU_FAST_MUL_EN
                     hi_d = fast_prod_s[2*WIDTH-1:WIDTH];
                     lo_d = fast_prod_s[WIDTH-1:0];
`else
                     opa_d   = {{WIDTH{1'b0}}, magnitude(srca_e, sa_s)};
                     opb_d   = magnitude(srcb_e, sb_s);
                     acc_d   = {(2*WIDTH){1'b0}};
                     neg_d   = sa_s ^ sb_s;
                     div_d   = 1'b0;
                     dz_d    = 1'b0;
                     cnt_d   = {CNT_W{1'b0}};
                     busy_d  = 1'b1;
                     state_d = ST_MUL;
`endif
                  end
                  OP_DIV, OP_DIVU: begin
                     div_zero_d = 1'b0;
                     opa_d   = {{WIDTH{1'b0}}, magnitude(srcb_e, sb_s)};
                     acc_d   = {{WIDTH{1'b0}}, magnitude(srca_e, sa_s)};
                     neg_d   = sa_s ^ sb_s;
                     rneg_d  = sa_s;
                     raw_d   = srca_e;
                     dz_d    = (srcb_e == {WIDTH{1'b0}});
                     div_d   = 1'b1;
                     cnt_d   = {CNT_W{1'b0}};
                     busy_d  = 1'b1;
                     state_d = ST_DIV;
                  end
                  OP_MTHI: hi_d = srca_e;
                  OP_MTLO: lo_d = srca_e;
                  default: begin
                     hi_d = hi_q;
                     lo_d = lo_q;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (opb_q[0]) begin
               acc_d = acc_q + opa_q;
            end else begin
               acc_d = acc_q;
            end
            opa_d = {opa_q[2*WIDTH-2:0], 1'b0};
            opb_d = {1'b0, opb_q[WIDTH-1:1]};
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == CNT_LAST) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = ST_FIX;
            end else begin
               state_d = ST_MUL;
            end
         end
         ST_DIV: begin
            if (!trial_s[WIDTH]) begin
               acc_d = {trial_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (cnt_q == CNT_LAST) begin
               cnt_d   = {CNT_W{1'b0}};
               state_d = ST_FIX;
            end else begin
               state_d = ST_DIV;
            end
         end
         ST_FIX: begin
            if (div_q && dz_q) begin
               lo_d       = {WIDTH{1'b1}};
               hi_d       = raw_q;
               div_zero_d = 1'b1;
            end else if (div_q) begin
               lo_d = quo_s;
               hi_d = rem_s;
            end else begin
               hi_d = prod_s[2*WIDTH-1:WIDTH];
               lo_d = prod_s[WIDTH-1:0];
            end
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         busy_q     <= 1'b0;
         cnt_q      <= {CNT_W{1'b0}};
         acc_q      <= {(2*WIDTH){1'b0}};
         opa_q      <= {(2*WIDTH){1'b0}};
         opb_q      <= {WIDTH{1'b0}};
         neg_q      <= 1'b0;
         rneg_q     <= 1'b0;
         div_q      <= 1'b0;
         dz_q       <= 1'b0;
         raw_q      <= {WIDTH{1'b0}};
         hi_q       <= {WIDTH{1'b0}};
         lo_q       <= {WIDTH{1'b0}};
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         neg_q      <= neg_d;
         rneg_q     <= rneg_d;
         div_q      <= div_d;
         dz_q       <= dz_d;
         raw_q      <= raw_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         div_zero_q <= div_zero_d;
      end
   end

endmodule
